// File: rtl/decoder_pkg.sv
// Shared load/store decode definitions: funct3 size codes, LSU FSM states,
// and a helper that classifies a size code as legal for the data bus.
package decoder_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // Codes 3, 6 and 7 have no load/store meaning and must never reach the bus.
    function automatic logic size_legal(input logic [2:0] size);
        return (size == LDST_B) || (size == LDST_H) || (size == LDST_W) ||
               (size == LDST_BU) || (size == LDST_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: byte enables, store-data replication,
// load-data extraction/extension and the alignment check.
module lsu_align
    import decoder_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] mem_rd_i,
    output logic [3:0]  be_o,
    output logic [31:0] wd_o,
    output logic [31:0] rd_o,
    output logic        misaligned_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Lane selection per access size; illegal sizes produce no enables.
    always_comb begin
        be_o         = 4'b0000;
        wd_o         = wd_i;
        rd_o         = 32'h0;
        misaligned_o = 1'b0;
        rd_byte      = mem_rd_i[{addr_i, 3'b000} +: 8];
        rd_half      = addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        case (size_i)
            LDST_B, LDST_BU: begin
                be_o = 4'b0001 << addr_i;
                wd_o = {4{wd_i[7:0]}};
                rd_o = (size_i == LDST_B) ? {{24{rd_byte[7]}}, rd_byte}
                                          : {24'h0, rd_byte};
            end
            LDST_H, LDST_HU: begin
                be_o         = 4'b0011 << {addr_i[1], 1'b0};
                wd_o         = {2{wd_i[15:0]}};
                misaligned_o = addr_i[0];
                rd_o         = (size_i == LDST_H) ? {{16{rd_half[15]}}, rd_half}
                                                  : {16'h0, rd_half};
            end
            LDST_W: begin
                be_o         = 4'b1111;
                misaligned_o = |addr_i;
                rd_o         = mem_rd_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_lsu_ctrl.sv
// Load/store controller: accepts one memory instruction in IDLE, runs a single
// req/ready bus transaction in BUSY (with optional timeout), and releases the
// core in RESP, pulsing the fault output for misaligned/illegal/timed-out accesses.
module riscv_lsu_ctrl
    import decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    // A zero TIMEOUT still needs a 1-bit counter so the logic stays well formed.
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_t        state_q, state_d;
    logic              we_q;
    logic [2:0]        size_q;
    logic [31:0]       addr_q;
    logic [31:0]       wd_q;
    logic [3:0]        be_q;
    logic [31:0]       rd_q;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              latch_en;
    logic              rd_en;
    logic              stall;

    logic [2:0]        al_size;
    logic [1:0]        al_addr;
    logic [3:0]        al_be;
    logic [31:0]       al_wd;
    logic [31:0]       al_rd;
    logic              al_misaligned;

    // The aligner sees the incoming request while idle, and the latched
    // request while the bus transaction is in flight (for load extraction).
    assign al_size = (state_q == BUSY) ? size_q      : core_size_i;
    assign al_addr = (state_q == BUSY) ? addr_q[1:0] : core_addr_i[1:0];

    lsu_align u_align (
        .size_i       (al_size),
        .addr_i       (al_addr),
        .wd_i         (core_wd_i),
        .mem_rd_i     (mem_rd_i),
        .be_o         (al_be),
        .wd_o         (al_wd),
        .rd_o         (al_rd),
        .misaligned_o (al_misaligned)
    );

    // Next-state, stall and latch/capture enables.
    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        cnt_d    = '0;
        latch_en = 1'b0;
        rd_en    = 1'b0;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    stall = 1'b1;
                    if (!size_legal(core_size_i) || al_misaligned) begin
                        fault_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        latch_en = 1'b1;
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
                // Ready wins over a timeout that expires in the same cycle.
                if (mem_ready_i) begin
                    rd_en   = !we_q;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    fault_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                fault_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and fault flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Request latches, captured only for accesses that will go to the bus.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q   <= 1'b0;
            size_q <= 3'd0;
            addr_q <= 32'h0;
            wd_q   <= 32'h0;
            be_q   <= 4'h0;
        end else if (latch_en) begin
            we_q   <= core_we_i;
            size_q <= core_size_i;
            addr_q <= core_addr_i;
            wd_q   <= al_wd;
            be_q   <= al_be;
        end
    end

    // Load result register: only a completed load updates it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q <= 32'h0;
        end else if (rd_en) begin
            rd_q <= al_rd;
        end
    end

    assign mem_req_o    = (state_q == BUSY);
    assign mem_we_o     = (state_q == BUSY) && we_q;
    assign mem_be_o     = (state_q == BUSY) ? be_q : 4'h0;
    assign mem_addr_o   = addr_q;
    assign mem_wd_o     = wd_q;
    assign core_rd_o    = rd_q;
    assign core_stall_o = stall;
    assign core_fault_o = (state_q == RESP) && fault_q;

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// Randomized scoreboard bench for riscv_lsu_ctrl: the driver computes the
// expected outcome of each access from the load/store rules and queues it; a
// monitor measures stall/request lengths and results and compares at RESP.
module tb_riscv_lsu_ctrl;

    localparam int unsigned TO = 16;

    logic        clk;
    logic        rst_n;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic [31:0] core_rd;
    logic        core_stall;
    logic        core_fault;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        mem_ready;

    riscv_lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_size_i  (core_size),
        .core_addr_i  (core_addr),
        .core_wd_i    (core_wd),
        .core_rd_o    (core_rd),
        .core_stall_o (core_stall),
        .core_fault_o (core_fault),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wd_o     (mem_wd),
        .mem_rd_i     (mem_rd),
        .mem_ready_i  (mem_ready)
    );

    typedef struct {
        bit          fault;
        logic [31:0] rd;
        int          stall_n;
        int          req_n;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          txn_id = 0;
    logic [31:0] model_rd = 32'h0;
    int          cur_delay = 0;   // BUSY cycle in which ready is given; 0 = never
    logic [31:0] cur_mem = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus responder: ready in the requested BUSY cycle; random ready noise
    // while no request is outstanding (must be ignored).
    initial begin
        int bcnt;
        bcnt = 0;
        mem_ready = 1'b0;
        mem_rd = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                bcnt++;
                if (bcnt == cur_delay) begin
                    mem_ready = 1'b1;
                    mem_rd = cur_mem;
                end else begin
                    mem_ready = 1'b0;
                    mem_rd = $urandom;
                end
            end else begin
                bcnt = 0;
                mem_ready = 1'($urandom_range(0, 1));
                mem_rd = $urandom;
            end
        end
    end

    // Monitor: measures each access and compares against the queued expectation.
    initial begin
        int st_n, rq_n;
        bit bad_idle;
        logic cap_we;
        logic [3:0] cap_be;
        logic [31:0] cap_wd, cap_addr;
        exp_t e;
        st_n = 0; rq_n = 0; bad_idle = 0;
        cap_we = 0; cap_be = 0; cap_wd = 0; cap_addr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                st_n = 0; rq_n = 0; bad_idle = 0;
            end else if (core_stall) begin
                st_n++;
                if (mem_req) begin
                    if (rq_n == 0) begin
                        cap_we = mem_we; cap_be = mem_be; cap_wd = mem_wd; cap_addr = mem_addr;
                    end
                    rq_n++;
                end else if (mem_be != 4'h0 || mem_we) begin
                    bad_idle = 1;
                end
            end else if (st_n > 0) begin
                if (mem_req || mem_we || mem_be != 4'h0) bad_idle = 1;
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("fault", {31'h0, core_fault}, {31'h0, e.fault});
                    chk("core_rd", core_rd, e.rd);
                    chk("stall_cycles", st_n, e.stall_n);
                    chk("req_cycles", rq_n, e.req_n);
                    chk("bus_idle_quiet", {31'h0, bad_idle}, 32'h0);
                    if (e.req_n > 0) begin
                        chk("mem_we", {31'h0, cap_we}, {31'h0, e.we});
                        chk("mem_be", {28'h0, cap_be}, {28'h0, e.be});
                        chk("mem_wd", cap_wd, e.wd);
                        chk("mem_addr", cap_addr, e.addr);
                    end
                    $display("txn %0d: fault=%0b rd=0x%08h stall=%0d req=%0d", txn_id,
                             core_fault, core_rd, st_n, rq_n);
                    txn_id++;
                end
                st_n = 0; rq_n = 0; bad_idle = 0;
            end else begin
                chk("idle_fault", {31'h0, core_fault}, 32'h0);
            end
        end
    end

    // Reference outcome of one access, from the load/store rules.
    function automatic exp_t model(input logic we, input logic [2:0] sz, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] mem, input int dly);
        exp_t e;
        int bytes;
        bit legal;
        logic [31:0] v;
        bytes = (sz == 3'd0 || sz == 3'd4) ? 1 : (sz == 3'd1 || sz == 3'd5) ? 2 : 4;
        legal = (sz == 3'd0 || sz == 3'd1 || sz == 3'd2 || sz == 3'd4 || sz == 3'd5);
        e.we = we; e.addr = a; e.be = 4'h0; e.wd = 32'h0;
        if (!legal || (a % bytes) != 0) begin
            e.fault = 1; e.stall_n = 1; e.req_n = 0; e.rd = model_rd;
            return e;
        end
        e.be = 4'(((1 << bytes) - 1) << (a % 4));
        for (int b = 0; b < 4; b++) e.wd[8*b +: 8] = wd[8*(b % bytes) +: 8];
        if (dly == 0 || dly > int'(TO)) begin
            e.fault = 1; e.stall_n = TO + 1; e.req_n = TO; e.rd = model_rd;
        end else begin
            e.fault = 0; e.stall_n = dly + 1; e.req_n = dly;
            if (!we) begin
                v = mem >> (8 * (a % 4));
                if (bytes == 1) begin
                    v = v & 32'hFF;
                    if (sz == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
                end else if (bytes == 2) begin
                    v = v & 32'hFFFF;
                    if (sz == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
                end
                model_rd = v;
            end
            e.rd = model_rd;
        end
        return e;
    endfunction

    // Issue one access; entered and left in a RESP cycle (or IDLE with early=0 at start).
    // gap 0 raises the request during RESP (ignored there) and holds it into IDLE.
    task automatic issue(input logic we, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] mem, input int dly,
                         input int gap);
        int guard;
        sb.push_back(model(we, sz, a, wd, mem, dly));
        cur_delay = dly;
        cur_mem = mem;
        core_we = we; core_size = sz; core_addr = a; core_wd = wd;
        if (gap == 0) begin
            core_req = 1'b1;
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            repeat (gap - 1) begin @(posedge clk); #1; end
            core_req = 1'b1;
        end
        @(posedge clk); #1;
        core_req = 1'b0;
        core_we = 1'($urandom); core_size = 3'($urandom); core_addr = $urandom; core_wd = $urandom;
        guard = 0;
        while (core_stall && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 40) chk("stall_release_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int dly, sel;
        logic [2:0] sz;
        logic [31:0] a;
        rst_n = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_size = 3'd0; core_addr = 32'h0; core_wd = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'h0, core_stall}, 32'h0);
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_rd", core_rd, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wd", mem_wd, 32'h0);
        chk("rst_fault", {31'h0, core_fault}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases (first one enters from IDLE via gap 1).
        issue(1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 1, 1);   // LB
        issue(1'b0, 3'd4, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 1, 1);   // LBU
        issue(1'b1, 3'd1, 32'h0000_0022, 32'h1234_5678, 32'h0, 1, 0);   // SH
        issue(1'b0, 3'd2, 32'h0000_1002, 32'h0, 32'h0, 1, 1);           // LW misaligned
        issue(1'b0, 3'd3, 32'h0000_1000, 32'h0, 32'h0, 1, 2);           // illegal size
        issue(1'b0, 3'd1, 32'h0000_0002, 32'h0, 32'h7FFF_0000, 4, 1);   // LH delayed
        issue(1'b0, 3'd2, 32'h0000_0040, 32'h0, 32'h0, 0, 1);           // timeout
        issue(1'b0, 3'd2, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 16, 0);  // ready at limit

        // Reset in the middle of a bus access.
        @(posedge clk); #1;
        cur_delay = 0;
        core_req = 1'b1; core_we = 1'b1; core_size = 3'd2; core_addr = 32'h0000_0ABC; core_wd = 32'h1111_2222;
        @(posedge clk); #1;
        core_req = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_busy_req", {31'h0, mem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'h0, mem_req}, 32'h0);
        chk("mid_rst_stall", {31'h0, core_stall}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_rd = 32'h0;
        @(posedge clk); #1;
        chk("post_rst_rd", core_rd, 32'h0);
        chk("post_rst_addr", mem_addr, 32'h0);
        chk("post_rst_wd", mem_wd, 32'h0);
        chk("post_rst_fault", {31'h0, core_fault}, 32'h0);
        chk("post_rst_be", {28'h0, mem_be}, 32'h0);

        // Randomized accesses.
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 9);
            dly = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(15, 17) : $urandom_range(1, 6);
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 3'd2) a[1:0] = 2'b00;
                else if (sz == 3'd1 || sz == 3'd5) a[0] = 1'b0;
            end
            issue(1'($urandom), sz, a, $urandom, $urandom, dly,
                  (n == 0) ? 1 : $urandom_range(0, 2));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
